// File: rtl/video_pkg.sv
// Shared types and constants for the per-line video fetch scheduler.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } vfs_state_e;

    localparam logic [6:0] WPL_ZX   = 7'd32;
    localparam logic [6:0] WPL_P16C = 7'd64;
    localparam logic [6:0] WPL_AG   = 7'd80;
    localparam logic [6:0] WPL_TEXT = 7'd80;

    function automatic logic [6:0] mode_wpl(
        input logic zx,
        input logic p_hmclr,
        input logic p_16c,
        input logic a_hmclr,
        input logic a_16c,
        input logic a_text
    );
        if (zx || p_hmclr)
            return WPL_ZX;
        if (p_16c)
            return WPL_P16C;
        if (a_hmclr || a_16c)
            return WPL_AG;
        if (a_text)
            return WPL_TEXT;
        return 7'd0;
    endfunction

endpackage

// File: rtl/video_credit_ctr.sv
// Up/down saturating counter; simultaneous inc and dec cancel out.
module video_credit_ctr
    import video_pkg::*;
#(
    parameter int             W    = 4,
    parameter logic [W-1:0]   MAX  = '1,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_nxt
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;

    always_comb begin
        w_nxt = r_cnt;
        if (i_inc && !i_dec && r_cnt != MAX)
            w_nxt = r_cnt + 1'b1;
        else if (i_dec && !i_inc && r_cnt != '0)
            w_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= INIT;
        else
            r_cnt <= w_nxt;
    end

    assign o_cnt = r_cnt;
    assign o_nxt = w_nxt;

endmodule

// File: rtl/video_fetch_sched.sv
// Per-line video fetch scheduler: budget, credit and outstanding-word throttle.
// Optional VFS_STATS_EN adds underrun_cnt and fetch_cnt outputs.
module video_fetch_sched
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic        vpix,
    input  logic        int_start,
    input  logic        mode_zx,
    input  logic        mode_p_hmclr,
    input  logic        mode_p_16c,
    input  logic        mode_a_hmclr,
    input  logic        mode_a_16c,
    input  logic        mode_a_text,
    output logic        video_go,
    input  logic        video_next,
    input  logic        video_strobe,
    input  logic        pix_pop,
    output logic        busy,
    output logic        underrun,
    input  logic        underrun_clr
`ifdef VFS_STATS_EN
    ,
    output logic [7:0]  underrun_cnt,
    output logic [15:0] fetch_cnt
`endif
);

    localparam int             CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  CMAX = CW'(FIFO_DEPTH);

    vfs_state_e    r_state;
    vfs_state_e    w_state_nxt;
    logic [6:0]    r_rem;
    logic [6:0]    w_rem_nxt;
    logic [6:0]    w_wpl;
    logic          r_go;
    logic          w_go_nxt;
    logic          r_underrun;
    logic          w_set_ur;
    logic          w_ack;
    logic          w_line;
    logic [CW-1:0] w_cred;
    logic [CW-1:0] w_cred_nxt;
    logic [2:0]    w_out;
    logic [2:0]    w_out_nxt;

    assign w_wpl  = mode_wpl(mode_zx, mode_p_hmclr, mode_p_16c,
                             mode_a_hmclr, mode_a_16c, mode_a_text);
    // Acks arriving while no request is up are protocol errors and dropped.
    assign w_ack  = video_next & r_go;
    assign w_line = line_start & vpix;

    video_credit_ctr #(
        .W    (CW),
        .MAX  (CMAX),
        .INIT (CMAX)
    ) u_credits (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (pix_pop),
        .i_dec (w_ack),
        .o_cnt (w_cred),
        .o_nxt (w_cred_nxt)
    );

    video_credit_ctr #(
        .W    (3),
        .MAX  (3'd7),
        .INIT (3'd0)
    ) u_outstanding (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_ack),
        .i_dec (video_strobe),
        .o_cnt (w_out),
        .o_nxt (w_out_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_set_ur    = 1'b0;
        if (int_start) begin
            w_rem_nxt   = '0;
            w_state_nxt = ST_DRAIN;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_line && w_wpl != '0) begin
                        w_rem_nxt   = w_wpl;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_line) begin
                        w_set_ur  = 1'b1;
                        w_rem_nxt = w_wpl;
                        if (w_wpl == '0)
                            w_state_nxt = ST_DRAIN;
                    end else if (w_ack) begin
                        w_rem_nxt = r_rem - 7'd1;
                        if (r_rem == 7'd1)
                            w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_line && w_wpl != '0) begin
                        w_rem_nxt   = w_wpl;
                        w_state_nxt = ST_FETCH;
                    end else if (w_out == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        // Built from next-state values so a request never outlives its limit.
        w_go_nxt = (w_state_nxt == ST_FETCH) && (w_rem_nxt != '0) &&
                   (w_cred_nxt != '0) && (w_out_nxt != 3'd7);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_go       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_go    <= w_go_nxt;
            if (w_set_ur)
                r_underrun <= 1'b1;
            else if (underrun_clr)
                r_underrun <= 1'b0;
        end
    end

    assign video_go = r_go;
    assign underrun = r_underrun;
    assign busy     = (r_state != ST_IDLE) || (w_out != '0);

`ifdef VFS_STATS_EN
    logic [7:0]  r_ur_cnt;
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ur_cnt    <= '0;
            r_fetch_cnt <= '0;
        end else begin
            if (underrun_clr)
                r_ur_cnt <= {7'd0, w_set_ur};
            else if (w_set_ur && r_ur_cnt != 8'hFF)
                r_ur_cnt <= r_ur_cnt + 8'd1;
            if (int_start)
                r_fetch_cnt <= '0;
            else if (w_ack && r_fetch_cnt != 16'hFFFF)
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_ur_cnt;
    assign fetch_cnt    = r_fetch_cnt;
`endif

endmodule
